// File: rtl/z80_stack_pop_seq.sv
// z80_stack_pop_seq
//   Runs the two memory-read M-cycles of a 16-bit stack pop (M3 reads the low
//   byte at SP, M4 reads the high byte at SP+1). T-states are counted from 1 to
//   TRD, and the WAIT_T T-state repeats while bus_wait_n is low. At the end the
//   block issues a single write-back pulse carrying the assembled word, the
//   destination code and SP+2. It also reports per-M-cycle T-state totals for
//   the trace port.
// Ports
//   clk, reset_n           clock (one T-state per rising edge), async active-low reset
//   start                  1-cycle request from the decoder (ignored while busy)
//   dst_sel, sp_in         destination code and SP, latched on accepted start
//   bus_wait_n, bus_rdata  memory wait request and read data
//   busy, bus_rd, bus_addr sequence status and read bus
//   mcycle_type, tstate    trace: cycle type code and current T-state (0 idle)
//   done, wb_dst, wb_data, sp_out   write-back pulse and its payload
//   tcyc_m3, tcyc_m4       T-states spent in M3/M4 including waits, saturating
module z80_stack_pop_seq #(
  parameter int unsigned TRD            = 3,
  parameter int unsigned WAIT_T         = 2,
  parameter logic [2:0]  CYCLE_NONE     = 3'd0,
  parameter logic [2:0]  CYCLE_RDWR_MEM = 3'd1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  dst_sel,
  input  logic [15:0] sp_in,
  input  logic        bus_wait_n,
  input  logic [7:0]  bus_rdata,
  output logic        busy,
  output logic        bus_rd,
  output logic [15:0] bus_addr,
  output logic [2:0]  mcycle_type,
  output logic [2:0]  tstate,
  output logic        done,
  output logic [2:0]  wb_dst,
  output logic [15:0] wb_data,
  output logic [15:0] sp_out,
  output logic [3:0]  tcyc_m3,
  output logic [3:0]  tcyc_m4
);

  localparam logic [2:0] TRD_T  = 3'(TRD);
  localparam logic [2:0] WAIT_S = 3'(WAIT_T);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_DONE
  } state_e;

  state_e      state_q,   state_d;
  logic [2:0]  tstate_q,  tstate_d;
  logic [15:0] sp_lat_q,  sp_lat_d;
  logic [2:0]  dst_lat_q, dst_lat_d;
  logic [7:0]  lo_q,      lo_d;
  logic [2:0]  wb_dst_q,  wb_dst_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic [15:0] sp_out_q,  sp_out_d;
  logic [3:0]  tcyc_m3_q, tcyc_m3_d;
  logic [3:0]  tcyc_m4_q, tcyc_m4_d;

  logic        reading;
  logic        in_wait;

  assign reading = (state_q == S_RD_LO) || (state_q == S_RD_HI);
  // The wait check takes priority over the end-of-cycle check so that a Tw
  // still repeats even when WAIT_T coincides with the last T-state.
  assign in_wait = (tstate_q == WAIT_S) && !bus_wait_n;

  always_comb begin
    state_d   = state_q;
    tstate_d  = tstate_q;
    sp_lat_d  = sp_lat_q;
    dst_lat_d = dst_lat_q;
    lo_d      = lo_q;
    wb_dst_d  = wb_dst_q;
    wb_data_d = wb_data_q;
    sp_out_d  = sp_out_q;
    tcyc_m3_d = tcyc_m3_q;
    tcyc_m4_d = tcyc_m4_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sp_lat_d  = sp_in;
          dst_lat_d = dst_sel;
          tcyc_m3_d = '0;
          tcyc_m4_d = '0;
          tstate_d  = 3'd1;
          state_d   = S_RD_LO;
        end
      end

      S_RD_LO, S_RD_HI: begin
        if (state_q == S_RD_LO) begin
          if (tcyc_m3_q != '1) tcyc_m3_d = tcyc_m3_q + 4'd1;
        end else begin
          if (tcyc_m4_q != '1) tcyc_m4_d = tcyc_m4_q + 4'd1;
        end

        if (in_wait) begin
          tstate_d = tstate_q;
        end else if (tstate_q == TRD_T) begin
          if (state_q == S_RD_LO) begin
            lo_d     = bus_rdata;
            tstate_d = 3'd1;
            state_d  = S_RD_HI;
          end else begin
            wb_data_d = {bus_rdata, lo_q};
            wb_dst_d  = dst_lat_q;
            sp_out_d  = sp_lat_q + 16'd2;
            tstate_d  = '0;
            state_d   = S_DONE;
          end
        end else begin
          tstate_d = tstate_q + 3'd1;
        end
      end

      S_DONE: begin
        tstate_d = '0;
        state_d  = S_IDLE;
      end

      default: begin
        tstate_d = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      tstate_q  <= '0;
      sp_lat_q  <= '0;
      dst_lat_q <= '0;
      lo_q      <= '0;
      wb_dst_q  <= '0;
      wb_data_q <= '0;
      sp_out_q  <= '0;
      tcyc_m3_q <= '0;
      tcyc_m4_q <= '0;
    end else begin
      state_q   <= state_d;
      tstate_q  <= tstate_d;
      sp_lat_q  <= sp_lat_d;
      dst_lat_q <= dst_lat_d;
      lo_q      <= lo_d;
      wb_dst_q  <= wb_dst_d;
      wb_data_q <= wb_data_d;
      sp_out_q  <= sp_out_d;
      tcyc_m3_q <= tcyc_m3_d;
      tcyc_m4_q <= tcyc_m4_d;
    end
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    bus_rd      = reading;
    mcycle_type = reading ? CYCLE_RDWR_MEM : CYCLE_NONE;
    done        = (state_q == S_DONE);
    bus_addr    = '0;
    if (state_q == S_RD_LO) bus_addr = sp_lat_q;
    if (state_q == S_RD_HI) bus_addr = sp_lat_q + 16'd1;
  end

  assign tstate  = tstate_q;
  assign wb_dst  = wb_dst_q;
  assign wb_data = wb_data_q;
  assign sp_out  = sp_out_q;
  assign tcyc_m3 = tcyc_m3_q;
  assign tcyc_m4 = tcyc_m4_q;

endmodule

// File: tb/tb_z80_stack_pop_seq.sv
// tb_z80_stack_pop_seq
//   Self-checking bench for z80_stack_pop_seq: a byte-array memory model
//   answers reads, each accepted pop pushes its expected write-back onto a
//   scoreboard queue, and a monitor pops and compares on every done pulse.
module tb_z80_stack_pop_seq;

  localparam int unsigned TRD    = 3;
  localparam int unsigned WAIT_T = 2;
  localparam logic [2:0]  C_NONE = 3'd0;
  localparam logic [2:0]  C_MEM  = 3'd1;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  dst_sel;
  logic [15:0] sp_in;
  logic        bus_wait_n;
  logic [7:0]  bus_rdata;
  logic        busy;
  logic        bus_rd;
  logic [15:0] bus_addr;
  logic [2:0]  mcycle_type;
  logic [2:0]  tstate;
  logic        done;
  logic [2:0]  wb_dst;
  logic [15:0] wb_data;
  logic [15:0] sp_out;
  logic [3:0]  tcyc_m3;
  logic [3:0]  tcyc_m4;

  z80_stack_pop_seq #(
    .TRD            (TRD),
    .WAIT_T         (WAIT_T),
    .CYCLE_NONE     (C_NONE),
    .CYCLE_RDWR_MEM (C_MEM)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dst_sel     (dst_sel),
    .sp_in       (sp_in),
    .bus_wait_n  (bus_wait_n),
    .bus_rdata   (bus_rdata),
    .busy        (busy),
    .bus_rd      (bus_rd),
    .bus_addr    (bus_addr),
    .mcycle_type (mcycle_type),
    .tstate      (tstate),
    .done        (done),
    .wb_dst      (wb_dst),
    .wb_data     (wb_data),
    .sp_out      (sp_out),
    .tcyc_m3     (tcyc_m3),
    .tcyc_m4     (tcyc_m4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  assign bus_rdata = mem[bus_addr];

  typedef struct {
    logic [2:0]  dst;
    logic [15:0] data;
    logic [15:0] sp;
    logic [3:0]  m3;
    logic [3:0]  m4;
  } exp_t;

  exp_t sb[$];

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] sat15(input int unsigned v);
    return (v > 15) ? 4'd15 : 4'(v);
  endfunction

  // Expected T-state number at offset j (0-based) inside an M-cycle with w waits.
  function automatic logic [2:0] exp_ts(input int unsigned j, input int unsigned w);
    if (j < WAIT_T - 1)  return 3'(j + 1);
    if (j < WAIT_T + w)  return 3'(WAIT_T);
    return 3'(j + 1 - w);
  endfunction

  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("wb_data", 32'(wb_data), 32'(e.data));
        check_eq("wb_dst",  32'(wb_dst),  32'(e.dst));
        check_eq("sp_out",  32'(sp_out),  32'(e.sp));
        check_eq("tcyc_m3", 32'(tcyc_m3), 32'(e.m3));
        check_eq("tcyc_m4", 32'(tcyc_m4), 32'(e.m4));
      end
    end
  end

  task automatic run_pop(input logic [15:0] sp, input logic [2:0] dst,
                         input int unsigned w3, input int unsigned w4,
                         input int unsigned extra_k, input int unsigned abort_k,
                         input bit noise);
    exp_t        e;
    int unsigned lat;
    bit          seen;
    logic [15:0] sp1;
    sp1    = sp + 16'd1;
    e.dst  = dst;
    e.data = {mem[sp1], mem[sp]};
    e.sp   = sp + 16'd2;
    e.m3   = sat15(TRD + w3);
    e.m4   = sat15(TRD + w4);
    lat    = 2 * TRD + 1 + w3 + w4;
    seen   = 1'b0;

    @(negedge clk);
    sp_in      = sp;
    dst_sel    = dst;
    start      = 1'b1;
    bus_wait_n = 1'b1;
    sb.push_back(e);

    for (int unsigned k = 1; k <= lat + 10 && !seen; k++) begin
      @(negedge clk);
      start = (k == extra_k);
      if (k == extra_k) sp_in = ~sp;
      bus_wait_n = !((k >= WAIT_T && k < WAIT_T + w3) ||
                     (k >= TRD + w3 + WAIT_T && k < TRD + w3 + WAIT_T + w4));
      if (noise && (k == 1 || k == TRD)) bus_wait_n = 1'b0;

      if (k == abort_k) begin
        reset_n = 1'b0;
        #1;
        check_eq("rst_busy",   32'(busy),        32'd0);
        check_eq("rst_rd",     32'(bus_rd),      32'd0);
        check_eq("rst_addr",   32'(bus_addr),    32'd0);
        check_eq("rst_tstate", 32'(tstate),      32'd0);
        check_eq("rst_mtype",  32'(mcycle_type), 32'(C_NONE));
        check_eq("rst_wbdata", 32'(wb_data),     32'd0);
        check_eq("rst_spout",  32'(sp_out),      32'd0);
        check_eq("rst_tcyc3",  32'(tcyc_m3),     32'd0);
        sb.delete();
        bus_wait_n = 1'b1;
        start      = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_done", 32'(done), 32'd0);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        return;
      end

      if (done) begin
        check_eq("latency", k, lat);
        seen = 1'b1;
      end else if (k < lat) begin
        if (k <= TRD + w3) begin
          check_eq("tstate_m3", 32'(tstate),   32'(exp_ts(k - 1, w3)));
          check_eq("addr_m3",   32'(bus_addr), 32'(sp));
        end else begin
          check_eq("tstate_m4", 32'(tstate),   32'(exp_ts(k - 1 - TRD - w3, w4)));
          check_eq("addr_m4",   32'(bus_addr), 32'(sp1));
        end
        check_eq("bus_rd", 32'(bus_rd),      32'd1);
        check_eq("mtype",  32'(mcycle_type), 32'(C_MEM));
      end
    end

    start      = 1'b0;
    bus_wait_n = 1'b1;
    if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("sb_empty",  32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    dst_sel    = '0;
    sp_in      = '0;
    bus_wait_n = 1'b1;
    for (int unsigned a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    mem[16'h1234] = 8'hCD;
    mem[16'h1235] = 8'hAB;
    mem[16'hFFFF] = 8'h5A;
    mem[16'h0000] = 8'hA5;

    #12;
    check_eq("reset_busy",   32'(busy),        32'd0);
    check_eq("reset_tstate", 32'(tstate),      32'd0);
    check_eq("reset_mtype",  32'(mcycle_type), 32'(C_NONE));
    check_eq("reset_done",   32'(done),        32'd0);
    check_eq("reset_wbdata", 32'(wb_data),     32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_pop(16'h1234, 3'd4, 0, 0, 0, 0, 1'b0);
    check_eq("t1_data",   32'(wb_data), 32'hABCD);
    check_eq("t1_sp_out", 32'(sp_out),  32'h1236);

    run_pop(16'hFFFF, 3'd5, 0, 0, 0, 0, 1'b0);
    check_eq("t2_sp_out", 32'(sp_out),  32'h0001);
    check_eq("t2_data",   32'(wb_data), 32'hA55A);

    run_pop(16'h2000, 3'd1, 2, 0, 0, 0, 1'b0);
    check_eq("t3_tcyc_m3", 32'(tcyc_m3), 32'd5);

    run_pop(16'h3000, 3'd2, 0, 0, 3, 0, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("t4_hold_data", 32'(wb_data), 32'({mem[16'h3001], mem[16'h3000]}));
    check_eq("t4_hold_busy", 32'(busy),    32'd0);

    run_pop(16'h4000, 3'd3, 0, 0, 0, 5, 1'b0);
    run_pop(16'h4000, 3'd3, 0, 0, 0, 0, 1'b0);

    run_pop(16'h5000, 3'd0, 0, 20, 0, 0, 1'b0);
    check_eq("t6_tcyc_m4", 32'(tcyc_m4), 32'd15);

    run_pop(16'h6000, 3'd6, 0, 0, 0, 0, 1'b1);

    for (int i = 0; i < 4; i++) begin
      run_pop(16'($urandom), 3'($urandom_range(0, 7)),
              $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
